// File: rtl/nim_match_ctrl.sv
// nim_match_ctrl: screen flow, pile status and scoring for the take-away game.
// One key acts per cycle; a commit and its round resolution land in one edge.
module nim_match_ctrl #(
    parameter int  PILES      = 10,
    parameter int  VW         = 4,
    parameter int  RW         = 3,
    parameter int  PASS_LIMIT = 3,
    localparam int CW         = $clog2(PILES),
    localparam int PW         = $clog2(PASS_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_up,
    input  logic                key_down,
    input  logic                key_left,
    input  logic                key_right,
    input  logic                key_enter,
    input  logic                key_space,
    input  logic [PILES*VW-1:0] init_status,
    output logic [PILES*VW-1:0] status,
    output logic [2:0]          screen,
    output logic [CW-1:0]       cursor,
    output logic [VW-1:0]       pending,
    output logic                player,
    output logic [RW-1:0]       win1,
    output logic [RW-1:0]       win2,
    output logic [RW-1:0]       target,
    output logic [PW-1:0]       pass1,
    output logic [PW-1:0]       pass2,
    output logic                round_end,
    output logic                winner
);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_HELP  = 3'd1,
        S_SETUP = 3'd2,
        S_PLAY  = 3'd3,
        S_OVER  = 3'd4
    } screen_e;

    typedef enum logic [2:0] {
        K_NONE, K_SPACE, K_ENTER, K_LEFT, K_RIGHT, K_UP, K_DOWN
    } key_e;

    screen_e             screen_q, screen_d;
    logic [PILES*VW-1:0] status_q, status_d;
    logic [CW-1:0]       cursor_q, cursor_d;
    logic [VW-1:0]       pending_q, pending_d;
    logic                player_q, player_d;
    logic [RW-1:0]       win1_q, win1_d;
    logic [RW-1:0]       win2_q, win2_d;
    logic [RW-1:0]       target_q, target_d;
    logic [PW-1:0]       pass1_q, pass1_d;
    logic [PW-1:0]       pass2_q, pass2_d;
    logic                round_end_q, round_end_d;
    logic                winner_q, winner_d;

    key_e                key;
    logic [VW-1:0]       cur_pile;
    logic [PILES*VW-1:0] post;
    logic                is_pass;
    logic [PW-1:0]       new_pass;
    logic                empty_win;
    logic                decided;
    logic                rw;
    logic [RW-1:0]       win_cnt;

    // The highest-priority pressed key is the only one considered.
    always_comb begin
        if (key_space)      key = K_SPACE;
        else if (key_enter) key = K_ENTER;
        else if (key_left)  key = K_LEFT;
        else if (key_right) key = K_RIGHT;
        else if (key_up)    key = K_UP;
        else if (key_down)  key = K_DOWN;
        else                key = K_NONE;
    end

    assign cur_pile = status_q[cursor_q*VW +: VW];

    always_comb begin
        screen_d    = screen_q;
        status_d    = status_q;
        cursor_d    = cursor_q;
        pending_d   = pending_q;
        player_d    = player_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        target_d    = target_q;
        pass1_d     = pass1_q;
        pass2_d     = pass2_q;
        round_end_d = 1'b0;
        winner_d    = winner_q;
        post        = status_q;
        is_pass     = 1'b0;
        new_pass    = '0;
        empty_win   = 1'b0;
        decided     = 1'b0;
        rw          = 1'b0;
        win_cnt     = '0;

        unique case (screen_q)
            S_TITLE: begin
                if (key == K_ENTER)      screen_d = S_SETUP;
                else if (key == K_SPACE) screen_d = S_HELP;
            end
            S_HELP: begin
                if (key == K_ENTER)      screen_d = S_SETUP;
                else if (key == K_SPACE) screen_d = S_TITLE;
            end
            S_SETUP: begin
                unique case (key)
                    K_UP: begin
                        if (target_q != '1) target_d = target_q + 1'b1;
                    end
                    K_DOWN: begin
                        if (target_q > RW'(1)) target_d = target_q - 1'b1;
                    end
                    K_ENTER: begin
                        screen_d  = S_PLAY;
                        status_d  = init_status;
                        win1_d    = '0;
                        win2_d    = '0;
                        pass1_d   = '0;
                        pass2_d   = '0;
                        player_d  = 1'b0;
                        cursor_d  = '0;
                        pending_d = init_status[VW-1:0];
                    end
                    default: ;
                endcase
            end
            S_PLAY: begin
                unique case (key)
                    K_ENTER: screen_d = S_TITLE;
                    K_LEFT: begin
                        cursor_d  = (cursor_q == '0) ? CW'(PILES - 1)
                                                     : cursor_q - 1'b1;
                        pending_d = status_q[cursor_d*VW +: VW];
                    end
                    K_RIGHT: begin
                        cursor_d  = (cursor_q == CW'(PILES - 1)) ? '0
                                                                 : cursor_q + 1'b1;
                        pending_d = status_q[cursor_d*VW +: VW];
                    end
                    K_UP: begin
                        if (pending_q < cur_pile) pending_d = pending_q + 1'b1;
                    end
                    K_DOWN: begin
                        if (pending_q != '0) pending_d = pending_q - 1'b1;
                    end
                    K_SPACE: begin
                        is_pass = (pending_q == cur_pile);
                        post[cursor_q*VW +: VW] = pending_q;
                        new_pass = is_pass ? (player_q ? pass2_q : pass1_q) + 1'b1
                                           : '0;
                        if (player_q) pass2_d = new_pass;
                        else          pass1_d = new_pass;
                        status_d = post;
                        player_d = ~player_q;
                        // A pass on an all-zero board is not an emptying win.
                        empty_win = !is_pass && (post == '0);
                        decided   = empty_win || (new_pass == PW'(PASS_LIMIT));
                        rw        = empty_win ? player_q : ~player_q;
                        if (decided) begin
                            round_end_d = 1'b1;
                            winner_d    = rw;
                            win_cnt     = (rw ? win2_q : win1_q) + 1'b1;
                            if (rw) win2_d = win_cnt;
                            else    win1_d = win_cnt;
                            pass1_d  = '0;
                            pass2_d  = '0;
                            player_d = ~rw;
                            cursor_d = '0;
                            if (win_cnt == target_q) begin
                                screen_d  = S_OVER;
                                pending_d = post[VW-1:0];
                            end else begin
                                status_d  = init_status;
                                pending_d = init_status[VW-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
            S_OVER: begin
                if (key == K_ENTER) screen_d = S_TITLE;
            end
            default: screen_d = S_TITLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screen_q    <= S_TITLE;
            status_q    <= init_status;
            cursor_q    <= '0;
            pending_q   <= init_status[VW-1:0];
            player_q    <= 1'b0;
            win1_q      <= '0;
            win2_q      <= '0;
            target_q    <= RW'(1);
            pass1_q     <= '0;
            pass2_q     <= '0;
            round_end_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            screen_q    <= screen_d;
            status_q    <= status_d;
            cursor_q    <= cursor_d;
            pending_q   <= pending_d;
            player_q    <= player_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            target_q    <= target_d;
            pass1_q     <= pass1_d;
            pass2_q     <= pass2_d;
            round_end_q <= round_end_d;
            winner_q    <= winner_d;
        end
    end

    assign screen    = screen_q;
    assign status    = status_q;
    assign cursor    = cursor_q;
    assign pending   = pending_q;
    assign player    = player_q;
    assign win1      = win1_q;
    assign win2      = win2_q;
    assign target    = target_q;
    assign pass1     = pass1_q;
    assign pass2     = pass2_q;
    assign round_end = round_end_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_nim_match_ctrl.sv
// tb_nim_match_ctrl: directed game scenarios plus random key traffic,
// every cycle compared against an array-based model of the game rules.
module tb_nim_match_ctrl;

    localparam int PILES      = 10;
    localparam int VW         = 4;
    localparam int RW         = 3;
    localparam int PASS_LIMIT = 3;

    localparam logic [5:0] K_SP = 6'b100000;
    localparam logic [5:0] K_EN = 6'b010000;
    localparam logic [5:0] K_LF = 6'b001000;
    localparam logic [5:0] K_RT = 6'b000100;
    localparam logic [5:0] K_UP = 6'b000010;
    localparam logic [5:0] K_DN = 6'b000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0;
    logic key_right = 1'b0, key_enter = 1'b0, key_space = 1'b0;
    logic [PILES*VW-1:0] init_status = '0;
    logic [PILES*VW-1:0] status;
    logic [2:0]          screen;
    logic [3:0]          cursor;
    logic [VW-1:0]       pending;
    logic                player;
    logic [RW-1:0]       win1, win2, target;
    logic [1:0]          pass1, pass2;
    logic                round_end, winner;

    int checks = 0;
    int errors = 0;

    int m_scr, m_cur, m_pend, m_ply, m_w1, m_w2, m_tgt, m_p1, m_p2, m_re, m_win;
    int m_pile[PILES];

    always #5 clk = ~clk;

    nim_match_ctrl #(
        .PILES(PILES), .VW(VW), .RW(RW), .PASS_LIMIT(PASS_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_up(key_up), .key_down(key_down),
        .key_left(key_left), .key_right(key_right),
        .key_enter(key_enter), .key_space(key_space),
        .init_status(init_status), .status(status),
        .screen(screen), .cursor(cursor), .pending(pending),
        .player(player), .win1(win1), .win2(win2), .target(target),
        .pass1(pass1), .pass2(pass2),
        .round_end(round_end), .winner(winner)
    );

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [PILES*VW-1:0] m_status();
        logic [PILES*VW-1:0] r;
        r = '0;
        for (int i = 0; i < PILES; i++) r[i*VW +: VW] = VW'(m_pile[i]);
        return r;
    endfunction

    function automatic logic [PILES*VW-1:0] rand_init();
        logic [PILES*VW-1:0] r;
        r = '0;
        if ($urandom_range(0, 7) != 0)
            for (int i = 0; i < PILES; i++) r[i*VW +: VW] = VW'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic load_piles();
        for (int i = 0; i < PILES; i++) m_pile[i] = int'(init_status[i*VW +: VW]);
    endtask

    task automatic model_reset();
        m_scr = 0; load_piles(); m_cur = 0; m_pend = m_pile[0];
        m_ply = 0; m_w1 = 0; m_w2 = 0; m_tgt = 1; m_p1 = 0; m_p2 = 0;
        m_re = 0; m_win = 0;
    endtask

    // 0 none, 1 space, 2 enter, 3 left, 4 right, 5 up, 6 down
    function automatic int sel(input logic [5:0] k);
        for (int i = 5; i >= 0; i--) if (k[i]) return 6 - i;
        return 0;
    endfunction

    task automatic commit();
        int mover, sum, rw, mp;
        bit passed, done;
        mover  = m_ply;
        passed = (m_pend == m_pile[m_cur]);
        m_pile[m_cur] = m_pend;
        if (mover == 0) m_p1 = passed ? m_p1 + 1 : 0;
        else            m_p2 = passed ? m_p2 + 1 : 0;
        mp = (mover == 0) ? m_p1 : m_p2;
        m_ply = 1 - mover;
        sum = 0;
        foreach (m_pile[i]) sum += m_pile[i];
        done = 1'b0; rw = 0;
        if (!passed && sum == 0) begin done = 1'b1; rw = mover; end
        else if (mp == PASS_LIMIT) begin done = 1'b1; rw = 1 - mover; end
        if (done) begin
            m_re = 1; m_win = rw;
            if (rw == 1) m_w2++; else m_w1++;
            m_p1 = 0; m_p2 = 0; m_ply = 1 - rw; m_cur = 0;
            if (((rw == 1) ? m_w2 : m_w1) == m_tgt) m_scr = 4;
            else load_piles();
            m_pend = m_pile[0];
        end
    endtask

    task automatic model_step(input logic [5:0] k);
        int key;
        key  = sel(k);
        m_re = 0;
        case (m_scr)
            0: if (key == 2) m_scr = 2; else if (key == 1) m_scr = 1;
            1: if (key == 2) m_scr = 2; else if (key == 1) m_scr = 0;
            2: begin
                if (key == 5 && m_tgt < (1 << RW) - 1) m_tgt++;
                else if (key == 6 && m_tgt > 1) m_tgt--;
                else if (key == 2) begin
                    m_scr = 3; load_piles(); m_w1 = 0; m_w2 = 0;
                    m_p1 = 0; m_p2 = 0; m_ply = 0; m_cur = 0; m_pend = m_pile[0];
                end
            end
            3: begin
                case (key)
                    2: m_scr = 0;
                    3: begin m_cur = (m_cur + PILES - 1) % PILES; m_pend = m_pile[m_cur]; end
                    4: begin m_cur = (m_cur + 1) % PILES; m_pend = m_pile[m_cur]; end
                    5: if (m_pend < m_pile[m_cur]) m_pend++;
                    6: if (m_pend > 0) m_pend--;
                    1: commit();
                    default: ;
                endcase
            end
            4: if (key == 2) m_scr = 0;
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("screen", 64'(screen), 64'(m_scr));
        check("status", 64'(status), 64'(m_status()));
        check("cursor", 64'(cursor), 64'(m_cur));
        check("pending", 64'(pending), 64'(m_pend));
        check("player", 64'(player), 64'(m_ply));
        check("win1", 64'(win1), 64'(m_w1));
        check("win2", 64'(win2), 64'(m_w2));
        check("target", 64'(target), 64'(m_tgt));
        check("pass1", 64'(pass1), 64'(m_p1));
        check("pass2", 64'(pass2), 64'(m_p2));
        check("round_end", 64'(round_end), 64'(m_re));
        check("winner", 64'(winner), 64'(m_win));
    endtask

    task automatic step(input logic [5:0] k);
        @(negedge clk);
        {key_space, key_enter, key_left, key_right, key_up, key_down} = k;
        @(posedge clk);
        model_step(k);
        #1;
        compare_all();
        {key_space, key_enter, key_left, key_right, key_up, key_down} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [5:0] rand_key();
        int w;
        w = $urandom_range(0, 99);
        if (w < 6)  return 6'b0;
        if (w < 10) return K_EN;
        if (w < 35) return K_SP;
        if (w < 45) return K_LF;
        if (w < 60) return K_RT;
        if (w < 75) return K_UP;
        return K_DN;
    endfunction

    initial begin
        init_status = 40'h1111111111;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_screen", 64'(screen), 64'd0);
        check("rst_status", 64'(status), 64'h1111111111);
        check("rst_target", 64'(target), 64'd1);
        check("rst_pending", 64'(pending), 64'd1);
        compare_all();
        rst_n = 1'b1;

        step(K_SP); check("nav_help", 64'(screen), 64'd1);
        step(K_SP); check("nav_title", 64'(screen), 64'd0);
        step(K_EN); check("nav_setup", 64'(screen), 64'd2);
        repeat (9) step(K_UP);
        check("tgt_sat_hi", 64'(target), 64'd7);
        repeat (9) step(K_DN);
        check("tgt_sat_lo", 64'(target), 64'd1);

        step(K_EN); check("play", 64'(screen), 64'd3);
        step(K_DN);
        step(K_SP);
        check("move_status", 64'(status), 64'h1111111110);
        check("move_player", 64'(player), 64'd1);
        check("move_pending", 64'(pending), 64'd0);

        step(K_LF);
        check("wrap_cursor", 64'(cursor), 64'd9);
        check("wrap_pending", 64'(pending), 64'd1);
        repeat (3) step(K_UP);
        check("pend_sat_hi", 64'(pending), 64'd1);
        repeat (2) step(K_DN);
        check("pend_sat_lo", 64'(pending), 64'd0);
        step(K_SP);
        step(K_RT);
        for (int p = 1; p <= 8; p++) begin
            step(K_RT); step(K_DN); step(K_SP);
        end
        check("win_pulse", 64'(round_end), 64'd1);
        check("win_winner", 64'(winner), 64'd1);
        check("win_win2", 64'(win2), 64'd1);
        check("win_over", 64'(screen), 64'd4);
        check("win_final", 64'(status), 64'd0);

        step(K_EN); step(K_EN); step(K_UP); step(K_EN);
        check("t2_target", 64'(target), 64'd2);
        step(K_SP);
        step(K_DN); step(K_SP);
        step(K_RT); step(K_SP);
        check("pass_cnt", 64'(pass1), 64'd2);
        step(K_DN); step(K_SP);
        step(K_RT); step(K_SP);
        check("ff_pulse", 64'(round_end), 64'd1);
        check("ff_winner", 64'(winner), 64'd1);
        check("ff_win2", 64'(win2), 64'd1);
        check("ff_status", 64'(status), 64'h1111111111);
        check("ff_player", 64'(player), 64'd0);
        check("ff_screen", 64'(screen), 64'd3);

        step(K_SP | K_LF);
        check("simul_cursor", 64'(cursor), 64'd0);
        check("simul_player", 64'(player), 64'd1);
        check("simul_pass1", 64'(pass1), 64'd1);
        do_reset();
        check("mid_rst_screen", 64'(screen), 64'd0);
        check("mid_rst_win2", 64'(win2), 64'd0);
        check("mid_rst_status", 64'(status), 64'h1111111111);

        init_status = rand_init();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 3) begin
                do_reset();
            end else begin
                if (r < 15) init_status = rand_init();
                step(rand_key());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
